id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of operand, immediate and result buses.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the bubble counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid_i  input  1  decode stage presents an instruction.
REQ-007 in_ready_o  output  1  stage accepts the presented instruction this cycle.
REQ-008 rs1_data_i, rs2_data_i  input  DATA_WIDTH  register-file read data.
REQ-009 imm_i  input  DATA_WIDTH  sign-extended immediate (LUI: upper 20 bits right-aligned).
REQ-010 rs1_addr_i, rs2_addr_i, rd_addr_i  input  5  source/destination register numbers.
REQ-011 alu_op_i  input  4  ALU operation code, passed unchanged.
REQ-012 alu_src_i  input  1  1: B operand is imm_i; 0: B operand is rs2.
REQ-013 reg_write_i  input  1  instruction writes rd.
REQ-014 exmem_reg_write_i, exmem_rd_i(5), exmem_result_i(DATA_WIDTH)  input  EX/MEM forwarding source.
REQ-015 memwb_reg_write_i, memwb_rd_i(5), memwb_result_i(DATA_WIDTH)  input  MEM/WB forwarding source.
REQ-016 flush_i  input  1  kill held and incoming instruction (taken branch).
REQ-017 out_ready_i  input  1  ALU/EX side consumes the held instruction.
REQ-018 out_valid_o  output  1  held instruction is valid.
REQ-019 alu_op_o  output  4  registered ALU operation code.
REQ-020 a_o, b_o  output  DATA_WIDTH  registered ALU operands A and B.
REQ-021 rd_addr_o  output  5; reg_write_o  output  1  registered destination info.
REQ-022 bubble_count_o  output  CNT_WIDTH  count of cycles with out_valid_o low.

Function
REQ-023 in_ready_o SHALL equal (!out_valid_o || out_ready_i) && !flush_i, combinationally.
REQ-024 Capture SHALL occur on a rising edge when in_valid_i && in_ready_o; all output registers load in that edge, latency 1 cycle.
REQ-025 Operand selection at capture, per source: EX/MEM match (reg_write, rd==rsN, rd!=0) first, else MEM/WB match, else register-file data.
REQ-026 x0 SHALL never be forwarded; rsN==0 selects register-file data.
REQ-027 b_o SHALL be imm_i when alu_src_i=1, regardless of rs2 forwarding matches.
REQ-028 Hold: out_valid_o=1 && out_ready_i=0 && !flush_i keeps alu_op_o, rd_addr_o, reg_write_o unchanged.
REQ-029 During hold, a_o (and b_o if not immediate) SHALL refresh each cycle from a matching forwarding source per REQ-025/026 priority; no match leaves the value unchanged. Stage stores held rs1/rs2 numbers and alu_src.
REQ-030 Drain: out_valid_o=1 && out_ready_i=1 and no capture SHALL clear out_valid_o next cycle.
REQ-031 Whenever out_valid_o becomes 0, alu_op_o=4'b0000, a_o=b_o=0, rd_addr_o=0, reg_write_o=0 (bubble = ADD 0+0, Zero asserted downstream).
REQ-032 flush_i=1 SHALL clear out_valid_o next cycle and suppress capture that cycle, overriding hold, drain and in_valid_i.
REQ-033 bubble_count_o SHALL increment by 1 each cycle out_valid_o=0, saturate at all-ones, never wrap.
REQ-034 Simultaneous drain and capture SHALL keep out_valid_o=1 with the new instruction's contents.

Reset
REQ-035 reset SHALL dominate flush and capture; next edge: out_valid_o=0, bubble outputs per REQ-031, stored rs numbers=0, bubble_count_o=0.
REQ-036 reset mid-hold SHALL discard the held instruction; no partial output update.

Verification
REQ-037 ADDI: rs1=5 data 10, imm=7, alu_src=1, op=0000, out_ready=1 -> next cycle out_valid=1, a_o=10, b_o=7, then bubble.
REQ-038 Forward priority: rs1=3, exmem rd=3 result 0x11, memwb rd=3 result 0x22 -> a_o=0x11; exmem write=0 -> a_o=0x22; rs1=0 with exmem rd=0 -> regfile data.
REQ-039 Hold refresh: out_ready=0 for 3 cycles, held rs2=4 alu_src=0, cycle 2 memwb rd=4 result 0x55 -> b_o=0x55, alu_op/rd unchanged, in_ready=0.
REQ-040 Flush: held valid, in_valid=1, flush=1 -> next cycle out_valid=0, all outputs 0, incoming not captured.
REQ-041 Counter: reset then 5 idle cycles -> bubble_count_o=5; preload near max, idle -> saturates at 0xFFFF.
REQ-042 Reset during hold with in_valid=1 -> out_valid=0, bubble_count_o=0, no capture.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, hold-time operand refresh,
// flush, bubble insertion and a saturating bubble-cycle counter.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [3:0]            alu_op_i,
  input  logic                  alu_src_i,
  input  logic                  reg_write_i,
  input  logic                  exmem_reg_write_i,
  input  logic [4:0]            exmem_rd_i,
  input  logic [DATA_WIDTH-1:0] exmem_result_i,
  input  logic                  memwb_reg_write_i,
  input  logic [4:0]            memwb_rd_i,
  input  logic [DATA_WIDTH-1:0] memwb_result_i,
  input  logic                  flush_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [3:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [4:0]            rd_addr_o,
  output logic                  reg_write_o,
  output logic [CNT_WIDTH-1:0]  bubble_count_o
);

  logic                  valid_q,     valid_d;
  logic [3:0]            alu_op_q,    alu_op_d;
  logic [DATA_WIDTH-1:0] a_q,         a_d;
  logic [DATA_WIDTH-1:0] b_q,         b_d;
  logic [4:0]            rd_q,        rd_d;
  logic                  reg_write_q, reg_write_d;
  logic [4:0]            rs1_q,       rs1_d;
  logic [4:0]            rs2_q,       rs2_d;
  logic                  alu_src_q,   alu_src_d;
  logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;

  logic                  capture;
  logic [DATA_WIDTH:0]   fwd_rs1_in, fwd_rs2_in, fwd_rs1_held, fwd_rs2_held;

  // Forwarding lookup: {hit, data}; EX/MEM beats MEM/WB, x0 never forwarded.
  function automatic logic [DATA_WIDTH:0] fwd_lookup(
    input logic [4:0]            rs,
    input logic                  ex_we,
    input logic [4:0]            ex_rd,
    input logic [DATA_WIDTH-1:0] ex_res,
    input logic                  wb_we,
    input logic [4:0]            wb_rd,
    input logic [DATA_WIDTH-1:0] wb_res
  );
    if (rs != 5'd0 && ex_we && ex_rd == rs)
      return {1'b1, ex_res};
    else if (rs != 5'd0 && wb_we && wb_rd == rs)
      return {1'b1, wb_res};
    else
      return {1'b0, {DATA_WIDTH{1'b0}}};
  endfunction

  assign fwd_rs1_in   = fwd_lookup(rs1_addr_i, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                                   memwb_reg_write_i, memwb_rd_i, memwb_result_i);
  assign fwd_rs2_in   = fwd_lookup(rs2_addr_i, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                                   memwb_reg_write_i, memwb_rd_i, memwb_result_i);
  assign fwd_rs1_held = fwd_lookup(rs1_q, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                                   memwb_reg_write_i, memwb_rd_i, memwb_result_i);
  assign fwd_rs2_held = fwd_lookup(rs2_q, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                                   memwb_reg_write_i, memwb_rd_i, memwb_result_i);

  assign in_ready_o = (!valid_q || out_ready_i) && !flush_i;
  assign capture    = in_valid_i && in_ready_o;

  // Next-state: flush > capture > drain > hold-refresh; idle keeps the bubble.
  always_comb begin
    valid_d     = valid_q;
    alu_op_d    = alu_op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    alu_src_d   = alu_src_q;
    cnt_d       = cnt_q;

    if (!valid_q && cnt_q != '1)
      cnt_d = cnt_q + CNT_WIDTH'(1);

    if (flush_i || (valid_q && out_ready_i && !capture)) begin
      valid_d     = 1'b0;
      alu_op_d    = '0;
      a_d         = '0;
      b_d         = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      alu_src_d   = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      alu_op_d    = alu_op_i;
      a_d         = fwd_rs1_in[DATA_WIDTH] ? fwd_rs1_in[DATA_WIDTH-1:0] : rs1_data_i;
      if (alu_src_i)
        b_d = imm_i;
      else
        b_d = fwd_rs2_in[DATA_WIDTH] ? fwd_rs2_in[DATA_WIDTH-1:0] : rs2_data_i;
      rd_d        = rd_addr_i;
      reg_write_d = reg_write_i;
      rs1_d       = rs1_addr_i;
      rs2_d       = rs2_addr_i;
      alu_src_d   = alu_src_i;
    end else if (valid_q) begin
      // Held instruction: late-arriving producer results replace stale operands.
      if (fwd_rs1_held[DATA_WIDTH])
        a_d = fwd_rs1_held[DATA_WIDTH-1:0];
      if (!alu_src_q && fwd_rs2_held[DATA_WIDTH])
        b_d = fwd_rs2_held[DATA_WIDTH-1:0];
    end
  end

  // State registers with synchronous reset to the bubble state.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      alu_op_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_src_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      alu_src_q   <= alu_src_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o    = valid_q;
  assign alu_op_o       = alu_op_q;
  assign a_o            = a_q;
  assign b_o            = b_q;
  assign rd_addr_o      = rd_q;
  assign reg_write_o    = reg_write_q;
  assign bubble_count_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: vector table through a scoreboard plus hold,
// flush, reset and counter sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i, in_ready_o;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [3:0]  alu_op_i;
  logic        alu_src_i, reg_write_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic        flush_i, out_ready_i, out_valid_o;
  logic [3:0]  alu_op_o;
  logic [31:0] a_o, b_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o;
  logic [15:0] bubble_count_o;

  logic        s_in_ready, s_out_valid, s_reg_write;
  logic [3:0]  s_alu_op;
  logic [31:0] s_a, s_b;
  logic [4:0]  s_rd;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
    .flush_i(flush_i), .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
    .alu_op_o(alu_op_o), .a_o(a_o), .b_o(b_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .bubble_count_o(bubble_count_o)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid_i(1'b0), .in_ready_o(s_in_ready),
    .rs1_data_i(32'd0), .rs2_data_i(32'd0), .imm_i(32'd0),
    .rs1_addr_i(5'd0), .rs2_addr_i(5'd0), .rd_addr_i(5'd0),
    .alu_op_i(4'd0), .alu_src_i(1'b0), .reg_write_i(1'b0),
    .exmem_reg_write_i(1'b0), .exmem_rd_i(5'd0), .exmem_result_i(32'd0),
    .memwb_reg_write_i(1'b0), .memwb_rd_i(5'd0), .memwb_result_i(32'd0),
    .flush_i(1'b0), .out_ready_i(1'b1), .out_valid_o(s_out_valid),
    .alu_op_o(s_alu_op), .a_o(s_a), .b_o(s_b), .rd_addr_o(s_rd),
    .reg_write_o(s_reg_write), .bubble_count_o(s_cnt)
  );

  typedef struct {
    logic [4:0]  rs1;  logic [31:0] rs1d;
    logic [4:0]  rs2;  logic [31:0] rs2d;
    logic [31:0] imm;  logic src;  logic [3:0] op;  logic [4:0] rd;  logic rw;
    logic exw; logic [4:0] exrd; logic [31:0] exres;
    logic mww; logic [4:0] mwrd; logic [31:0] mwres;
    logic [31:0] ea;   logic [31:0] eb;
  } vec_t;

  typedef struct {
    logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] rd; logic rw;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    rs1_addr_i = v.rs1;  rs1_data_i = v.rs1d;
    rs2_addr_i = v.rs2;  rs2_data_i = v.rs2d;
    imm_i = v.imm;  alu_src_i = v.src;  alu_op_i = v.op;
    rd_addr_i = v.rd;  reg_write_i = v.rw;
    exmem_reg_write_i = v.exw;  exmem_rd_i = v.exrd;  exmem_result_i = v.exres;
    memwb_reg_write_i = v.mww;  memwb_rd_i = v.mwrd;  memwb_result_i = v.mwres;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.op = v.op; e.a = v.ea; e.b = v.eb; e.rd = v.rd; e.rw = v.rw;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got valid=%0b expected queued entry", name, out_valid_o);
    end else begin
      e = sb.pop_front();
      chk({name, ".valid"}, {31'd0, out_valid_o}, 32'd1);
      chk({name, ".op"}, {28'd0, alu_op_o}, {28'd0, e.op});
      chk({name, ".a"}, a_o, e.a);
      chk({name, ".b"}, b_o, e.b);
      chk({name, ".rd"}, {27'd0, rd_addr_o}, {27'd0, e.rd});
      chk({name, ".rw"}, {31'd0, reg_write_o}, {31'd0, e.rw});
    end
  endtask

  task automatic chk_bubble(input string name);
    chk({name, ".valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({name, ".op"}, {28'd0, alu_op_o}, 32'd0);
    chk({name, ".a"}, a_o, 32'd0);
    chk({name, ".b"}, b_o, 32'd0);
    chk({name, ".rd"}, {27'd0, rd_addr_o}, 32'd0);
    chk({name, ".rw"}, {31'd0, reg_write_o}, 32'd0);
  endtask

  initial begin
    //             rs1    rs1d          rs2    rs2d          imm           src   op     rd     rw    exw   exrd   exres         mww   mwrd   mwres         ea            eb
    tbl[0] = '{5'd5,  32'd10,       5'd0,  32'd0,        32'd7,        1'b1, 4'd0,  5'd1,  1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        32'd10,       32'd7};
    tbl[1] = '{5'd3,  32'h99,       5'd6,  32'h66,       32'd0,        1'b0, 4'd1,  5'd2,  1'b1, 1'b1, 5'd3,  32'h11,       1'b1, 5'd3,  32'h22,       32'h11,       32'h66};
    tbl[2] = '{5'd3,  32'h99,       5'd6,  32'h66,       32'd0,        1'b0, 4'd2,  5'd3,  1'b1, 1'b0, 5'd3,  32'h11,       1'b1, 5'd3,  32'h22,       32'h22,       32'h66};
    tbl[3] = '{5'd0,  32'h77,       5'd0,  32'h88,       32'd0,        1'b0, 4'd3,  5'd4,  1'b0, 1'b1, 5'd0,  32'h11,       1'b1, 5'd0,  32'h22,       32'h77,       32'h88};
    tbl[4] = '{5'd9,  32'd9,        5'd4,  32'h40,       32'd0,        1'b0, 4'd4,  5'd5,  1'b1, 1'b1, 5'd4,  32'h44,       1'b1, 5'd4,  32'h55,       32'd9,        32'h44};
    tbl[5] = '{5'd9,  32'd9,        5'd4,  32'h40,       32'h123,      1'b1, 4'd5,  5'd6,  1'b1, 1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  32'd0,        32'd9,        32'h123};
    tbl[6] = '{5'd3,  32'h99,       5'd2,  32'h200,      32'd0,        1'b0, 4'd6,  5'd7,  1'b0, 1'b1, 5'd2,  32'h11,       1'b1, 5'd3,  32'h33,       32'h33,       32'h11};
    tbl[7] = '{5'd31, 32'h1234,     5'd0,  32'd0,        32'hFFFF_FFF0,1'b1, 4'd15, 5'd31, 1'b1, 1'b0, 5'd31, 32'h5,        1'b1, 5'd31, 32'hABCD,     32'hABCD,     32'hFFFF_FFF0};

    reset = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    drive_vec(tbl[0]);
    step(); step();
    chk_bubble("reset");
    chk("reset.cnt", {16'd0, bubble_count_o}, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready_o}, 32'd1);
    reset = 1'b0;

    repeat (5) step();
    chk("idle5.cnt", {16'd0, bubble_count_o}, 32'd5);
    chk("idle5.small_cnt", {28'd0, s_cnt}, 32'd5);

    // Back-to-back captures: each capture drains the previous instruction.
    for (int i = 0; i < 8; i++) begin
      drive_vec(tbl[i]);
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      push_exp(tbl[i]);
      step();
      sb_check($sformatf("vec%0d", i));
    end
    in_valid_i = 1'b0;
    drive_vec('{default: '0});
    step();
    chk_bubble("drain");

    // Hold with operand refresh from MEM/WB.
    drive_vec('{5'd1, 32'h10, 5'd4, 32'h40, 32'd0, 1'b0, 4'b0101, 5'd7, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h10, 32'h40});
    push_exp('{5'd1, 32'h10, 5'd4, 32'h40, 32'd0, 1'b0, 4'b0101, 5'd7, 1'b1,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h10, 32'h40});
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    step();
    sb_check("hold.cap");
    drive_vec('{5'd2, 32'hAA, 5'd3, 32'hBB, 32'd0, 1'b0, 4'b1000, 5'd9, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0});
    #1 chk("hold1.in_ready", {31'd0, in_ready_o}, 32'd0);
    step();
    chk("hold1.b", b_o, 32'h40);
    chk("hold1.op", {28'd0, alu_op_o}, 32'h5);
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd4; memwb_result_i = 32'h55;
    #1 chk("hold2.in_ready", {31'd0, in_ready_o}, 32'd0);
    step();
    chk("hold2.b", b_o, 32'h55);
    chk("hold2.a", a_o, 32'h10);
    chk("hold2.op", {28'd0, alu_op_o}, 32'h5);
    chk("hold2.rd", {27'd0, rd_addr_o}, 32'd7);
    chk("hold2.valid", {31'd0, out_valid_o}, 32'd1);
    memwb_reg_write_i = 1'b0;
    step();
    chk("hold3.b", b_o, 32'h55);
    chk("hold3.rd", {27'd0, rd_addr_o}, 32'd7);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    chk_bubble("hold.drain");

    // Flush kills the held instruction and the incoming one.
    drive_vec('{5'd2, 32'h20, 5'd0, 32'd0, 32'h30, 1'b1, 4'd3, 5'd5, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h20, 32'h30});
    push_exp('{5'd2, 32'h20, 5'd0, 32'd0, 32'h30, 1'b1, 4'd3, 5'd5, 1'b1,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h20, 32'h30});
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    step();
    sb_check("flush.cap");
    drive_vec(tbl[1]);
    flush_i = 1'b1; out_ready_i = 1'b1;
    #1 chk("flush.in_ready", {31'd0, in_ready_o}, 32'd0);
    step();
    chk_bubble("flush");
    flush_i = 1'b0; in_valid_i = 1'b0;
    step();
    chk_bubble("flush.after");

    // Reset mid-hold with a pending input.
    drive_vec(tbl[4]);
    push_exp(tbl[4]);
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    step();
    sb_check("rsthold.cap");
    drive_vec(tbl[5]);
    reset = 1'b1;
    step();
    chk_bubble("rsthold");
    chk("rsthold.cnt", {16'd0, bubble_count_o}, 32'd0);
    reset = 1'b0; in_valid_i = 1'b0;

    // Counter: count idle cycles, narrow instance saturates.
    repeat (20) step();
    chk("cnt20", {16'd0, bubble_count_o}, 32'd20);
    chk("small.sat", {28'd0, s_cnt}, 32'hF);
    step();
    chk("small.sat2", {28'd0, s_cnt}, 32'hF);
    chk("sb.empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
